// File: rtl/spawn_in_arbiter.sv
// spawn_in_arbiter: packet-atomic round-robin merge of per-accelerator
// spawn streams into one registered spawn_in AXI-Stream (tid = source).
//
// Ports:
//   clk, rstn            clock, async active-low reset
//   acc_tvalid/tready    per-source handshake (MAX_ACCS bits each)
//   acc_tdata/tlast      per-source beat, source i at [i*DATA_W +: DATA_W]
//   spawn_in_*           merged registered stream to the manager
//   pkt_count            packets fully forwarded (tlast handshakes)
module spawn_in_arbiter #(
  parameter int MAX_ACCS = 16,
  parameter int DATA_W   = 64,
  localparam int IW      = (MAX_ACCS > 1) ? $clog2(MAX_ACCS) : 1
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [MAX_ACCS-1:0]        acc_tvalid,
  output logic [MAX_ACCS-1:0]        acc_tready,
  input  logic [MAX_ACCS*DATA_W-1:0] acc_tdata,
  input  logic [MAX_ACCS-1:0]        acc_tlast,
  output logic                       spawn_in_tvalid,
  input  logic                       spawn_in_tready,
  output logic [IW-1:0]              spawn_in_tid,
  output logic [DATA_W-1:0]          spawn_in_tdata,
  output logic                       spawn_in_tlast,
  output logic [31:0]                pkt_count
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t      state_q;
  logic [IW-1:0] rr_ptr_q;
  logic [IW-1:0] grant_q;

  logic          found;
  logic [IW-1:0] pick;
  logic [IW-1:0] idx;
  int            jj;

  logic              out_free;
  logic              accept;
  logic [DATA_W-1:0] sel_data;
  logic              sel_last;

  // Search starts just after the last served source, so it ends up
  // with the lowest priority on the next arbitration.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    jj    = 0;
    for (int k = 1; k <= MAX_ACCS; k++) begin
      jj = int'(rr_ptr_q) + k;
      if (jj >= MAX_ACCS) jj = jj - MAX_ACCS;
      idx = IW'(jj);
      if (!found && acc_tvalid[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  // Ready depends only on state and the output register, never on
  // any source valid.
  assign out_free = !spawn_in_tvalid || spawn_in_tready;

  always_comb begin
    acc_tready = '0;
    if (state_q == LOCKED) acc_tready[grant_q] = out_free;
  end

  assign accept   = (state_q == LOCKED) && out_free
                    && acc_tvalid[grant_q];
  assign sel_data = acc_tdata[int'(grant_q)*DATA_W +: DATA_W];
  assign sel_last = acc_tlast[grant_q];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q         <= IDLE;
      rr_ptr_q        <= IW'(MAX_ACCS - 1);
      grant_q         <= '0;
      spawn_in_tvalid <= 1'b0;
      spawn_in_tid    <= '0;
      spawn_in_tdata  <= '0;
      spawn_in_tlast  <= 1'b0;
      pkt_count       <= '0;
    end else begin
      if (spawn_in_tvalid && spawn_in_tready && spawn_in_tlast)
        pkt_count <= pkt_count + 32'd1;

      if (accept) begin
        spawn_in_tvalid <= 1'b1;
        spawn_in_tid    <= grant_q;
        spawn_in_tdata  <= sel_data;
        spawn_in_tlast  <= sel_last;
      end else if (spawn_in_tready) begin
        spawn_in_tvalid <= 1'b0;
      end

      unique case (state_q)
        IDLE: begin
          if (found) begin
            grant_q <= pick;
            state_q <= LOCKED;
          end
        end
        LOCKED: begin
          if (accept && sel_last) begin
            rr_ptr_q <= grant_q;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spawn_in_arbiter.sv
// tb_spawn_in_arbiter: scoreboard bench for spawn_in_arbiter.
// Source queues feed beats; expected output order is queued per test.
module tb_spawn_in_arbiter;
  localparam int N  = 16;
  localparam int IW = 4;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic [N-1:0]     acc_tvalid;
  logic [N-1:0]     acc_tready;
  logic [N*64-1:0]  acc_tdata;
  logic [N-1:0]     acc_tlast;
  logic             spawn_in_tvalid;
  logic             spawn_in_tready;
  logic [IW-1:0]    spawn_in_tid;
  logic [63:0]      spawn_in_tdata;
  logic             spawn_in_tlast;
  logic [31:0]      pkt_count;

  spawn_in_arbiter #(.MAX_ACCS(N), .DATA_W(64)) dut (
    .clk(clk),
    .rstn(rstn),
    .acc_tvalid(acc_tvalid),
    .acc_tready(acc_tready),
    .acc_tdata(acc_tdata),
    .acc_tlast(acc_tlast),
    .spawn_in_tvalid(spawn_in_tvalid),
    .spawn_in_tready(spawn_in_tready),
    .spawn_in_tid(spawn_in_tid),
    .spawn_in_tdata(spawn_in_tdata),
    .spawn_in_tlast(spawn_in_tlast),
    .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [IW-1:0] tid;
    logic [63:0]   data;
    logic          last;
  } beat_t;

  logic [64:0] src_q [N][$];
  beat_t       exp_q[$];
  logic        rdy_q[$];

  int    errors = 0;
  int    checks = 0;
  int    cyc = 0;
  int    first_out = -1;
  int    last_out = -1;
  logic  prev_stall = 1'b0;
  beat_t prev_beat;

  function automatic bit any_src();
    bit r;
    r = 1'b0;
    for (int i = 0; i < N; i++)
      if (src_q[i].size() > 0) r = 1'b1;
    return r;
  endfunction

  task automatic load_pkt(input int src, input logic [63:0] base,
                          input int n);
    for (int k = 0; k < n; k++)
      src_q[src].push_back({base + 64'(k), k == n - 1});
  endtask

  task automatic exp_pkt(input int src, input logic [63:0] base,
                         input int n);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.tid  = IW'(src);
      b.data = base + 64'(k);
      b.last = (k == n - 1);
      exp_q.push_back(b);
    end
  endtask

  // One clock: drive at negedge, sample #1 later, handshakes land at
  // the following posedge.
  task automatic cycle();
    beat_t cur;
    beat_t e;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      acc_tvalid[i] = src_q[i].size() > 0;
      if (src_q[i].size() > 0) begin
        acc_tdata[i*64 +: 64] = src_q[i][0][64:1];
        acc_tlast[i]          = src_q[i][0][0];
      end else begin
        acc_tdata[i*64 +: 64] = '0;
        acc_tlast[i]          = 1'b0;
      end
    end
    spawn_in_tready = (rdy_q.size() > 0) ? rdy_q.pop_front() : 1'b1;
    #1;
    cur = {spawn_in_tid, spawn_in_tdata, spawn_in_tlast};
    if (prev_stall) begin
      checks++;
      if (spawn_in_tvalid !== 1'b1 || cur !== prev_beat) begin
        errors++;
        $display("FAIL hold: got v=%0b %h, want v=1 %h",
                 spawn_in_tvalid, cur, prev_beat);
      end
    end
    if (spawn_in_tvalid && !spawn_in_tready) begin
      checks++;
      if (acc_tready !== '0) begin
        errors++;
        $display("FAIL stall_ready: got %h, want 0", acc_tready);
      end
    end
    if (spawn_in_tvalid && spawn_in_tready) begin
      if (first_out < 0) first_out = cyc;
      last_out = cyc;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL beat: got tid=%0d data=%h last=%0b, want none",
                 cur.tid, cur.data, cur.last);
      end else begin
        e = exp_q.pop_front();
        if (cur !== e) begin
          errors++;
          $display("FAIL beat: got tid=%0d data=%h last=%0b, want tid=%0d data=%h last=%0b",
                   cur.tid, cur.data, cur.last, e.tid, e.data, e.last);
        end
      end
    end
    for (int i = 0; i < N; i++)
      if (acc_tvalid[i] && acc_tready[i]) void'(src_q[i].pop_front());
    prev_stall = spawn_in_tvalid && !spawn_in_tready;
    prev_beat  = cur;
    cyc++;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() > 0 || any_src()) && n < budget) begin
      cycle();
      n++;
    end
    checks++;
    if (exp_q.size() > 0 || any_src()) begin
      errors++;
      $display("FAIL drain: got %0d beats left, want 0", exp_q.size());
    end
    cycle();
  endtask

  task automatic clear_tb();
    for (int i = 0; i < N; i++) src_q[i].delete();
    exp_q.delete();
    rdy_q.delete();
    acc_tvalid      = '0;
    acc_tlast       = '0;
    acc_tdata       = '0;
    spawn_in_tready = 1'b1;
    prev_stall      = 1'b0;
    first_out       = -1;
    last_out        = -1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    clear_tb();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic check_pc(input string nm, input logic [31:0] want);
    checks++;
    if (pkt_count !== want) begin
      errors++;
      $display("FAIL %s pkt_count: got %0d, want %0d", nm, pkt_count, want);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rstn = 1'b0;
    clear_tb();
    #1;
    checks++;
    if (spawn_in_tvalid !== 1'b0 || spawn_in_tlast !== 1'b0) begin
      errors++;
      $display("FAIL rst_valid: got v=%0b l=%0b, want 0 0",
               spawn_in_tvalid, spawn_in_tlast);
    end
    checks++;
    if (spawn_in_tid !== '0 || spawn_in_tdata !== '0) begin
      errors++;
      $display("FAIL rst_data: got tid=%0d data=%h, want 0 0",
               spawn_in_tid, spawn_in_tdata);
    end
    checks++;
    if (acc_tready !== '0) begin
      errors++;
      $display("FAIL rst_ready: got %h, want 0", acc_tready);
    end
    check_pc("rst", 32'd0);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_single_pkt();
    int start;
    do_reset();
    load_pkt(0, 64'hA0, 3);
    exp_pkt(0, 64'hA0, 3);
    start = cyc;
    drain(50);
    checks++;
    if (first_out - start != 2) begin
      errors++;
      $display("FAIL latency: got %0d, want 2", first_out - start);
    end
    checks++;
    if (last_out - first_out != 2) begin
      errors++;
      $display("FAIL stream: got %0d, want 2", last_out - first_out);
    end
    check_pc("single", 32'd1);
  endtask

  task automatic test_round_robin();
    do_reset();
    load_pkt(5, 64'h500, 2);
    load_pkt(2, 64'h200, 2);
    load_pkt(1, 64'h100, 2);
    exp_pkt(1, 64'h100, 2);
    exp_pkt(2, 64'h200, 2);
    exp_pkt(5, 64'h500, 2);
    drain(80);
    checks++;
    if (last_out - first_out != 7) begin
      errors++;
      $display("FAIL rr_span: got %0d, want 7", last_out - first_out);
    end
    check_pc("rr", 32'd3);
  endtask

  task automatic test_fairness();
    do_reset();
    for (int k = 0; k < 4; k++) load_pkt(3, 64'h300 + 64'(k*16), 1);
    exp_pkt(3, 64'h300, 1);
    exp_pkt(7, 64'h700, 1);
    for (int k = 1; k < 4; k++) exp_pkt(3, 64'h300 + 64'(k*16), 1);
    cycle();
    load_pkt(7, 64'h700, 1);
    drain(80);
    check_pc("fair", 32'd5);
  endtask

  task automatic test_backpressure();
    do_reset();
    rdy_q = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    load_pkt(2, 64'hB0, 4);
    exp_pkt(2, 64'hB0, 4);
    drain(80);
    checks++;
    if (last_out - first_out != 5) begin
      errors++;
      $display("FAIL bp_span: got %0d, want 5", last_out - first_out);
    end
    check_pc("bp", 32'd1);
  endtask

  task automatic test_gap();
    int n;
    do_reset();
    src_q[4].push_back({64'h400, 1'b0});
    src_q[4].push_back({64'h401, 1'b0});
    load_pkt(6, 64'h600, 1);
    exp_pkt(4, 64'h400, 4);
    exp_pkt(6, 64'h600, 1);
    n = 0;
    while (src_q[4].size() > 0 && n < 20) begin
      cycle();
      n++;
    end
    repeat (5) begin
      cycle();
      checks++;
      if (acc_tready[6] !== 1'b0 ||
          (spawn_in_tvalid && spawn_in_tid !== 4'd4)) begin
        errors++;
        $display("FAIL gap: got rdy6=%0b tid=%0d, want 0 4",
                 acc_tready[6], spawn_in_tid);
      end
    end
    src_q[4].push_back({64'h402, 1'b0});
    src_q[4].push_back({64'h403, 1'b1});
    drain(80);
    check_pc("gap", 32'd2);
  endtask

  task automatic test_mid_reset();
    do_reset();
    load_pkt(0, 64'hD0, 1);
    exp_pkt(0, 64'hD0, 1);
    drain(40);
    check_pc("pre_rst", 32'd1);
    load_pkt(0, 64'hE0, 3);
    exp_pkt(0, 64'hE0, 3);
    repeat (3) cycle();
    #1;
    rstn = 1'b0;
    #1;
    checks++;
    if (spawn_in_tvalid !== 1'b0 || acc_tready !== '0) begin
      errors++;
      $display("FAIL async_rst: got v=%0b rdy=%h, want 0 0",
               spawn_in_tvalid, acc_tready);
    end
    check_pc("async_rst", 32'd0);
    clear_tb();
    repeat (2) @(negedge clk);
    #2;
    rstn = 1'b1;
    load_pkt(0, 64'hC0, 2);
    exp_pkt(0, 64'hC0, 2);
    drain(40);
    check_pc("post_rst", 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

  initial begin
    clear_tb();
    test_reset();
    test_single_pkt();
    test_round_robin();
    test_fairness();
    test_backpressure();
    test_gap();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
